// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one external pipelined FP32 multiplier among NUM_REQ
// requesters. Round-robin grant, registered operands, a tag pipeline matched
// to the multiplier latency, and a registered one-hot response back to the issuer.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   issue_en      allows new grants; in-flight operations always drain
//   req_valid     per-requester request strobe
//   req_a, req_b  packed operands, requester i at [32i+31:32i]
//   req_ready     one-hot grant (combinational)
//   mul_a, mul_b  registered multiplier operands
//   mul_out       multiplier result
//   rsp_valid     one-hot, one-cycle response strobe
//   rsp_data      registered result
//   rsp_id        index of the answered requester
//   busy          any tag stage valid or a response is being presented
//   inflight_cnt  number of valid tag stages, saturating
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned ID_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic [31:0]             mul_out,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy,
  output logic [3:0]              inflight_cnt
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LAST    = MUL_LATENCY;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [DATA_W-1:0]          mul_a_q, mul_a_d;
  logic [DATA_W-1:0]          mul_b_q, mul_b_d;
  logic [LAST:0]              tag_vld_q, tag_vld_d;
  logic [LAST:0][ID_W-1:0]    tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]          rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
  logic                       busy_q, busy_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       gnt_found_c;
  logic [ID_W-1:0]            gnt_id_c;
  logic [DATA_W-1:0]          gnt_a_c;
  logic [DATA_W-1:0]          gnt_b_c;

  // Round-robin search upward from ptr, wrapping at NUM_REQ-1.
  always_comb begin
    int unsigned idx;
    idx         = '0;
    gnt_found_c = 1'b0;
    gnt_id_c    = '0;
    gnt_a_c     = '0;
    gnt_b_c     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (issue_en && !gnt_found_c && req_valid[idx]) begin
        gnt_found_c = 1'b1;
        gnt_id_c    = ID_W'(idx);
        gnt_a_c     = req_a[idx*DATA_W +: DATA_W];
        gnt_b_c     = req_b[idx*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = gnt_found_c ? (NUM_REQ'(1) << gnt_id_c) : '0;

  // Next state: issue, tag shift, response capture, status.
  always_comb begin
    int unsigned pop;
    ptr_d       = ptr_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    pop         = '0;

    if (gnt_found_c) begin
      ptr_d   = ID_W'((32'(gnt_id_c) + 32'd1) % NUM_REQ);
      mul_a_d = gnt_a_c;
      mul_b_d = gnt_b_c;
    end

    // Stage 0 is refilled every edge; a bubble enters when nothing is granted.
    tag_vld_d = {tag_vld_q[LAST-1:0], gnt_found_c};
    tag_id_d  = {tag_id_q[LAST-1:0], gnt_id_c};

    // Last tag stage lines up with a stable mul_out.
    if (tag_vld_q[LAST]) begin
      rsp_valid_d = NUM_REQ'(1) << tag_id_q[LAST];
      rsp_data_d  = mul_out;
      rsp_id_d    = tag_id_q[LAST];
    end

    for (int unsigned k = 0; k <= LAST; k++) begin
      pop = pop + 32'(tag_vld_d[k]);
    end
    cnt_d  = (pop > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(pop);
    busy_d = (|tag_vld_d) || (|rsp_valid_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_id       = rsp_id_q;
  assign busy         = busy_q;
  assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;

  localparam int N  = 4;
  localparam int ML = 3;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              issue_en = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [32*N-1:0]   req_a = '0;
  logic [32*N-1:0]   req_b = '0;
  logic [N-1:0]      req_ready;
  logic [31:0]       mul_a, mul_b, mul_out;
  logic [N-1:0]      rsp_valid;
  logic [31:0]       rsp_data;
  logic [IW-1:0]     rsp_id;
  logic              busy;
  logic [3:0]        inflight_cnt;

  fp_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(ML), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .inflight_cnt(inflight_cnt)
  );

  initial forever #5 clk = ~clk;

  // Stand-in multiplier: known products for the directed operands, a fixed scramble otherwise.
  function automatic logic [31:0] mul_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
      {32'h00000000, 32'h7F800000}: return 32'h7FAAAAAA;
      default:                      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endcase
  endfunction

  // Multiplier pipeline with no reset: result stable ML edges after mul_a/mul_b change.
  logic [31:0] mp [ML];
  always @(posedge clk) begin
    mp[0] <= mul_fn(mul_a, mul_b);
    for (int k = 1; k < ML; k++) mp[k] <= mp[k-1];
  end
  assign mul_out = mp[ML-1];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of issued operations, each with the edge it issued on.
  typedef struct {
    int          id;
    logic [31:0] d;
    int          issued;
  } ent_t;

  ent_t        mq[$];
  int          m_ptr = 0;
  int          m_k = 0;
  logic [31:0] m_a = '0, m_b = '0, m_last_d = '0;
  int          m_last_id = 0;

  function automatic int model_grant();
    int idx;
    if (!issue_en) return -1;
    for (int i = 0; i < N; i++) begin
      idx = (m_ptr + i) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Compare every cycle on the falling edge, then advance the model for the next rising edge.
  always @(negedge clk) begin
    int g;
    int age;
    int e_cnt;
    logic e_busy;
    logic [N-1:0] e_ready, e_rv;
    if (rst) begin
      mq.delete();
      m_ptr = 0; m_a = '0; m_b = '0; m_last_d = '0; m_last_id = 0;
    end
    g = model_grant();
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    e_cnt = 0; e_busy = 1'b0; e_rv = '0;
    foreach (mq[j]) begin
      age = m_k - mq[j].issued;
      if (age <= ML) e_cnt++;
      if (age <= ML + 1) e_busy = 1'b1;
      if (age == ML + 1) e_rv[mq[j].id] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_data", rsp_data, m_last_d);
    chk("rsp_id", 32'(rsp_id), 32'(m_last_id));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("inflight_cnt", 32'(inflight_cnt), 32'(e_cnt));
    chk("mul_a", mul_a, m_a);
    chk("mul_b", mul_b, m_b);
    if (!rst) begin
      m_k++;
      if (g >= 0) begin
        mq.push_back('{id: g, d: mul_fn(req_a[g*32 +: 32], req_b[g*32 +: 32]), issued: m_k});
        m_a   = req_a[g*32 +: 32];
        m_b   = req_b[g*32 +: 32];
        m_ptr = (g + 1) % N;
      end
      while (mq.size() > 0 && (m_k - mq[0].issued) > ML + 1) void'(mq.pop_front());
      foreach (mq[j]) begin
        if (m_k - mq[j].issued == ML + 1) begin
          m_last_d  = mq[j].d;
          m_last_id = mq[j].id;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst rsp_data", rsp_data, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst inflight", 32'(inflight_cnt), 32'h0);
    chk("rst mul_a", mul_a, 32'h0);
    step();
    rst = 1'b0;

    // Single operation from requester 1: 2.0 * 3.0
    req_a[63:32] = 32'h40000000;
    req_b[63:32] = 32'h40400000;
    req_valid    = 4'b0010;
    #1 chk("single ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single inflight", 32'(inflight_cnt), 32'h1);
    chk("single busy", 32'(busy), 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("single rsp_valid", 32'(rsp_valid), 32'h2);
    chk("single rsp_id", 32'(rsp_id), 32'h1);
    chk("single rsp_data", rsp_data, 32'h40C00000);
    repeat (3) step();

    // All four continuously from reset: 1.5 * 1.5
    rst = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = 32'h3FC00000;
      req_b[i*32 +: 32] = 32'h3FC00000;
    end
    req_valid = 4'b1111;
    rst = 1'b0;
    #1 chk("stream first ready", 32'(req_ready), 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stream inflight", 32'(inflight_cnt), 32'h4);
    @(negedge clk);
    chk("stream rsp_valid", 32'(rsp_valid), 32'h1);
    chk("stream rsp_data", rsp_data, 32'h40100000);
    step();
    req_valid = '0;
    repeat (6) step();

    // Wrap-around: move ptr to 3, then requesters 3 and 0
    req_valid = 4'b0100;
    step();
    req_a[127:96] = 32'h40000000;
    req_b[127:96] = 32'h40400000;
    req_valid = 4'b1001;
    #1 chk("wrap ready 3", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0001;
    #1 chk("wrap ready 0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wrap rsp_id 3", 32'(rsp_id), 32'h3);
    chk("wrap rsp_data 3", rsp_data, 32'h40C00000);
    @(negedge clk);
    chk("wrap rsp_id 0", 32'(rsp_id), 32'h0);
    chk("wrap rsp_data 0", rsp_data, 32'h40100000);
    repeat (2) step();

    // issue_en low with two operations in flight
    req_valid = 4'b1111;
    step();
    step();
    issue_en = 1'b0;
    #1 chk("hold ready", 32'(req_ready), 32'h0);
    repeat (3) step();
    chk("hold rsp 1", 32'(rsp_valid), 32'h2);
    step();
    chk("hold rsp 2", 32'(rsp_valid), 32'h4);
    step();
    issue_en = 1'b1;
    #1 chk("resume ready", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    repeat (6) step();

    // Reset mid-flight, then 0 * inf from requester 2
    req_valid = 4'b1111;
    repeat (3) step();
    req_valid = '0;
    repeat (3) step();
    chk("pre-reset rsp", 32'(rsp_valid), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("mid rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid rst rsp_data", rsp_data, 32'h0);
    chk("mid rst rsp_id", 32'(rsp_id), 32'h0);
    chk("mid rst busy", 32'(busy), 32'h0);
    chk("mid rst inflight", 32'(inflight_cnt), 32'h0);
    chk("mid rst mul_b", mul_b, 32'h0);
    step();
    step();
    rst = 1'b0;
    req_a[95:64] = 32'h00000000;
    req_b[95:64] = 32'h7F800000;
    req_valid = 4'b1100;
    #1 chk("post rst ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    repeat (3) step();
    chk("nan early", 32'(rsp_valid), 32'h0);
    step();
    chk("nan rsp_valid", 32'(rsp_valid), 32'h4);
    chk("nan rsp_id", 32'(rsp_id), 32'h2);
    chk("nan rsp_data", rsp_data, 32'h7FAAAAAA);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one pipelined single-precision floating-point multiplier among NUM_REQ requesters.
- The multiplier's output is valid MUL_LATENCY clock edges after its inputs are applied, and it has no valid, stall or reset signals of its own.
- This block arbitrates requests round-robin and drives the multiplier operands from registers.
- It carries a requester tag down a shift pipeline that matches the multiplier's latency, then captures each result and returns it to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 3, edges from the multiplier sampling its inputs to a stable multiplier output.
- ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_en  input  1  when low, no new grants; operations already in flight drain normally.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_a  input  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  input  32*NUM_REQ  operand B, packed the same way as req_a.
- req_ready  output  NUM_REQ  one-hot grant (combinational).
- mul_a  output  32  registered operand A to the multiplier.
- mul_b  output  32  registered operand B to the multiplier.
- mul_out  input  32  multiplier result.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle result strobe.
- rsp_data  output  32  registered result, shared by all requesters.
- rsp_id  output  ID_W  index of the requester being answered.
- busy  output  1  high while any operation is in flight or a response is pending.
- inflight_cnt  output  4  number of valid tag stages, saturating at 15.

Behaviour:
- Reset (asynchronous, active-high) clears: the round-robin pointer, the tag pipeline and all valid bits. All outputs go to 0: mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy, inflight_cnt.
- A reset asserted mid-operation discards every in-flight operation and produces no responses for them. Garbage remaining inside the multiplier is ignored because all tags are cleared.
- Arbitration (combinational):
  - If issue_en=1, grant the first i with req_valid[i]=1, searching upward from ptr and wrapping from NUM_REQ-1 to 0.
  - req_ready = one-hot of the granted requester, or all zeros if there is no request or issue_en=0.
- Handshake rules:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - A requester holds req_valid and its operands stable until it is granted.
  - req_valid must not depend on req_ready.
  - No backpressure on responses: requesters must accept rsp_valid in the cycle it is asserted.
- Pointer update: on a transfer from requester g, ptr <= (g+1) mod NUM_REQ. Without a transfer, ptr holds.
- Issue (edge E0 of a transfer):
  - mul_a/mul_b load the granted operands; otherwise they hold their previous values.
  - Tag stage 0 loads {valid=1, id=g}; with no transfer, stage 0 valid=0.
- Tag pipeline:
  - Stages 0..MUL_LATENCY shift every edge unconditionally.
  - Stage k valid after edge Ek means mul_out reflects that operation once k = MUL_LATENCY.
- Capture (edge E(MUL_LATENCY+1)):
  - If the last tag stage is valid: rsp_data <= mul_out, rsp_id <= id, rsp_valid <= onehot(id).
  - Otherwise rsp_valid <= 0, and rsp_data and rsp_id hold.
- Latency: rsp_valid is high during the cycle after edge E(MUL_LATENCY+1), i.e. 4 cycles after the transfer edge at default parameters.
- Throughput: one operation per cycle. Responses return in issue order.
- busy = OR of all tag valid bits OR any rsp_valid bit.
- inflight_cnt = population count of the tag valid bits (stages 0..MUL_LATENCY), excluding the response register.
- issue_en falling while requests are pending: no grants from that cycle on, ptr holds, and in-flight operations still complete.
- Simultaneous transfer and response in the same cycle is normal pipelined operation; both proceed independently.

Test Plan:
- Single operation: req_valid=0010, req_a[63:32]=0x40000000, req_b[63:32]=0x40400000 for one cycle → req_ready=0010. rsp_valid=0010, rsp_id=1 and rsp_data=0x40C00000 exactly 4 cycles after the transfer edge. busy high throughout; inflight_cnt peaks at 1.
- All four requesters asserting continuously from reset, with 1.5*1.5 (0x3FC00000 × 0x3FC00000) → grants 0,1,2,3,0,1,… one per cycle. Responses rsp_id 0,1,2,3,… each with rsp_data=0x40100000, on consecutive cycles. inflight_cnt reaches 4.
- Wrap-around: advance ptr to 3, then req_valid=1001 → requester 3 granted first, then requester 0. Responses return in the order 3, 0.
- issue_en=0 for 5 cycles with req_valid=1111 and two operations in flight → req_ready=0000. The two in-flight responses still appear. After issue_en=1, arbitration resumes at the held ptr.
- Reset mid-flight: issue 3 operations back-to-back, assert rst between the 2nd and 3rd response cycles → all outputs 0 immediately. No further rsp_valid, even with the multiplier's pipeline still full. The first request after reset is granted from ptr=0.
- Special values through arbitration: requester 2 sends 0x00000000 × 0x7F800000 → rsp_data equals the multiplier's NaN pattern 0x7FAAAAAA with rsp_id=2.
